dmem_arbiter: RTL

//  Shares the single-port 256x16 synchronous data memory between the processor control unit
//  (CPU port) and a host/debug loader port (HOST port). CPU has fixed priority; the host is

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_rd_tag_pipe.sv | 32 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read owner and the
// read-tag record that follows each granted read through the RAM latency.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        S_CPU_PRI,
        S_HOST_LOCK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU};

    function automatic logic tag_hit(input rd_tag_t tag, input owner_t who);
        return tag.valid && (tag.owner == who);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The arbiter takes the slave view; requesters and RAM together form the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              host_req;
    logic              host_wr;
    logic              host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_req, host_wr, host_lock, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output ram_addr, ram_wr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_req, host_wr, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  ram_addr, ram_wr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Delay line for read tags: a tag entering with a granted read leaves exactly
// STAGES cycles later, aligned with the RAM read data it describes.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t tag_p [STAGES];

    // Clearing the tags drops every in-flight read, so none is delivered after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                tag_p[i] <= RD_TAG_IDLE;
            end
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i < STAGES; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign tag_out = tag_p[STAGES-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one synchronous data RAM between the CPU (fixed priority) and a
// host/debug loader (anti-starvation forcing plus short locked bursts).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int HW_W = $clog2(STARVE_MAX + 1);
    localparam int LC_W = $clog2(LOCK_MAX + 1);
    localparam logic [HW_W-1:0] HW_MAX = HW_W'(STARVE_MAX);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_MAX);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [HW_W-1:0]   host_wait;
    logic [HW_W-1:0]   host_wait_nx;
    logic [LC_W-1:0]   lock_cnt;
    logic [LC_W-1:0]   lock_cnt_nx;
    logic              cpu_win;
    logic              host_win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] rd_data;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    function automatic logic [HW_W-1:0] wait_sat_inc(input logic [HW_W-1:0] v);
        return (v == HW_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CPU_PRI;
            host_wait <= '0;
            lock_cnt  <= '0;
        end else begin
            state     <= state_nx;
            host_wait <= host_wait_nx;
            lock_cnt  <= lock_cnt_nx;
        end
    end

    // Grants are combinational and forced low while reset is asserted
    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        cpu_win     = 1'b0;
        host_win    = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_CPU_PRI: begin
                    if (bus.host_req && (host_wait == HW_MAX)) begin
                        host_win = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpu_win = 1'b1;
                    end else if (bus.host_req) begin
                        host_win = 1'b1;
                    end
                    if (host_win && bus.host_lock) begin
                        state_nx    = S_HOST_LOCK;
                        lock_cnt_nx = LC_W'(1);
                    end
                end
                S_HOST_LOCK: begin
                    host_win = bus.host_req;
                    // The grant taken at LC_MAX is the last one of the burst
                    if (!bus.host_req || !bus.host_lock || (lock_cnt == LC_MAX)) begin
                        state_nx    = S_CPU_PRI;
                        lock_cnt_nx = '0;
                    end else begin
                        lock_cnt_nx = lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx    = S_CPU_PRI;
                    lock_cnt_nx = '0;
                end
            endcase
        end
    end

    always_comb begin
        host_wait_nx = wait_sat_inc(host_wait);
        if (!bus.host_req || host_win) begin
            host_wait_nx = '0;
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        if (cpu_win) begin
            win_addr  = bus.cpu_addr;
            win_wdata = bus.cpu_wdata;
        end else if (host_win) begin
            win_addr  = bus.host_addr;
            win_wdata = bus.host_wdata;
        end
    end

    assign bus.cpu_gnt   = cpu_win;
    assign bus.host_gnt  = host_win;
    assign bus.ram_addr  = win_addr;
    assign bus.ram_wdata = win_wdata;
    assign bus.ram_wr    = (cpu_win && bus.cpu_wr) || (host_win && bus.host_wr);

    always_comb begin
        tag_in       = RD_TAG_IDLE;
        tag_in.valid = (cpu_win && !bus.cpu_wr) || (host_win && !bus.host_wr);
        tag_in.owner = host_win ? OWN_HOST : OWN_CPU;
    end

    // ---- read tag pipeline: grant cycle -> RD_LAT cycles later ----
    rd_tag_pipe #(
        .STAGES (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // ---- read return: steer RAM data to the tag owner only ----
    assign rd_data         = bus.ram_rdata;
    assign bus.cpu_rvalid  = tag_hit(tag_out, OWN_CPU);
    assign bus.host_rvalid = tag_hit(tag_out, OWN_HOST);
    assign bus.cpu_rdata   = tag_hit(tag_out, OWN_CPU)  ? rd_data : '0;
    assign bus.host_rdata  = tag_hit(tag_out, OWN_HOST) ? rd_data : '0;

    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.cpu_gnt && bus.host_gnt));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.cpu_rvalid && bus.host_rvalid));

endmodule
